// File: rtl/sonar_pkg.sv
// Shared sonar definitions: FSM state codes,
// 50 MHz timing defaults and BCD helpers.
package sonar_pkg;

  typedef enum logic [2:0] {
    S_INICIAL   = 3'd0,
    S_ESPERA    = 3'd1,
    S_MEDE_TRIG = 3'd2,
    S_ATRASO    = 3'd3,
    S_ECO       = 3'd4,
    S_FINAL     = 3'd5,
    S_ERRO      = 3'd7
  } estado_t;

  localparam int R_50M        = 2941;
  localparam int N_50M        = 12;
  localparam int TRIG_MIN_50M = 500;
  localparam int ATRASO_50M   = 20000;
  localparam int TIMEOUT_50M  = 1900000;
  localparam int D_MAX_ECO    = 400;

  function automatic logic [9:0] bcd2bin(
    input logic [3:0] d2,
    input logic [3:0] d1,
    input logic [3:0] d0
  );
    return 10'(d2) * 10'd100
         + 10'(d1) * 10'd10
         + 10'(d0);
  endfunction

  function automatic logic bcd_ok(
    input logic [3:0] d2,
    input logic [3:0] d1,
    input logic [3:0] d0
  );
    return (d2 <= 4'd9)
        && (d1 <= 4'd9)
        && (d0 <= 4'd9);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Generic mod-M counter with synchronous clear.
// fim flags M-1, meio flags M/2.
module contador_m #(
  parameter int M = 10,
  parameter int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim,
  output logic meio
);

  logic [W-1:0] q_q, q_d;

  // next count: clear wins, wrap at M-1
  always_comb begin
    q_d = q_q;
    if (zera) begin
      q_d = '0;
    end else if (conta) begin
      if (q_q == W'(M - 1)) q_d = '0;
      else                  q_d = q_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clock) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign fim  = (q_q == W'(M - 1));
  assign meio = (q_q == W'(M / 2));

endmodule

// File: rtl/emulador_eco.sv
// HC-SR04 responder: trigger in, BCD-coded echo out.
// Optional ECO_TIMEOUT_EN: D > 400 gives a fixed timeout echo.
module emulador_eco
  import sonar_pkg::*;
#(
  parameter int R          = R_50M,
  parameter int N          = N_50M,
  parameter int T_TRIG_MIN = TRIG_MIN_50M,
  parameter int T_ATRASO   = ATRASO_50M,
  parameter int T_TIMEOUT  = TIMEOUT_50M
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [3:0] digito0,
  input  logic [3:0] digito1,
  input  logic [3:0] digito2,
  output logic       echo,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] db_estado
);

  estado_t    state_q, state_d;
  logic       trig_s1_q, trig_s2_q, trig_s3_q;
  logic       trig_ok_q;
  logic [9:0] rem_q;
  logic       echo_q, pronto_q, erro_q;
  logic       rise, captura, dig_ok;
  logic [9:0] d_bin;
  logic       tw_conta, tw_fim;
  logic       dly_fim, tick_fim;
  logic       unused_meio_tw;
  logic       unused_meio_dly;
  logic       unused_meio_tick;

  assign rise   = trig_s2_q & ~trig_s3_q;
  assign d_bin  = bcd2bin(digito2, digito1, digito0);
  assign dig_ok = bcd_ok(digito2, digito1, digito0);

  // espera already saw one high sample, so
  // mede_trig needs T_TRIG_MIN-1 more
  assign tw_conta = (state_q == S_MEDE_TRIG)
                  && trig_s2_q;
  assign captura  = (state_q == S_MEDE_TRIG)
                  && !trig_s2_q && trig_ok_q
                  && dig_ok;

  contador_m #(.M(T_TRIG_MIN - 1)) u_tw (
    .clock (clock),
    .reset (reset),
    .zera  (state_q != S_MEDE_TRIG),
    .conta (tw_conta),
    .fim   (tw_fim),
    .meio  (unused_meio_tw)
  );

  contador_m #(.M(T_ATRASO + 1)) u_dly (
    .clock (clock),
    .reset (reset),
    .zera  (state_q != S_ATRASO),
    .conta (state_q == S_ATRASO),
    .fim   (dly_fim),
    .meio  (unused_meio_dly)
  );

  contador_m #(.M(R), .W(N)) u_tick (
    .clock (clock),
    .reset (reset),
    .zera  (state_q != S_ECO),
    .conta (state_q == S_ECO),
    .fim   (tick_fim),
    .meio  (unused_meio_tick)
  );

`ifdef ECO_TIMEOUT_EN
  logic tmo_q;
  logic tmo_fim;
  logic unused_meio_tmo;

  contador_m #(.M(T_TIMEOUT)) u_tmo (
    .clock (clock),
    .reset (reset),
    .zera  (state_q != S_ECO),
    .conta ((state_q == S_ECO) && tmo_q),
    .fim   (tmo_fim),
    .meio  (unused_meio_tmo)
  );

  // out-of-range flag latched with the distance
  always_ff @(posedge clock) begin
    if (reset)        tmo_q <= 1'b0;
    else if (captura) tmo_q <= (d_bin > 10'(D_MAX_ECO));
  end
`else
  localparam int unused_t_timeout = T_TIMEOUT;
`endif

  // two-flop synchronizer plus edge history
  always_ff @(posedge clock) begin
    if (reset) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
    end else begin
      trig_s1_q <= trigger;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INICIAL: state_d = S_ESPERA;
      S_ESPERA: begin
        if (rise) state_d = S_MEDE_TRIG;
      end
      S_MEDE_TRIG: begin
        if (!trig_s2_q) begin
          if (!trig_ok_q)   state_d = S_ESPERA;
          else if (!dig_ok) state_d = S_ERRO;
          else              state_d = S_ATRASO;
        end
      end
      S_ATRASO: begin
        if (dly_fim) begin
          if (rem_q == 10'd0) state_d = S_FINAL;
          else                state_d = S_ECO;
        end
      end
      S_ECO: begin
`ifdef ECO_TIMEOUT_EN
        if (tmo_q) begin
          if (tmo_fim) state_d = S_FINAL;
        end else
`endif
        if (tick_fim && rem_q == 10'd1)
          state_d = S_FINAL;
      end
      S_FINAL:  state_d = S_ESPERA;
      S_ERRO:   state_d = S_ESPERA;
      default:  state_d = S_INICIAL;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_INICIAL;
      echo_q   <= 1'b0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      echo_q   <= (state_d == S_ECO);
      pronto_q <= (state_d == S_FINAL)
               || (state_d == S_ERRO);
      if (state_d == S_ERRO) erro_q <= 1'b1;
      else if (captura)      erro_q <= 1'b0;
    end
  end

  // trigger-width flag and remaining-cm counter
  always_ff @(posedge clock) begin
    if (reset) begin
      trig_ok_q <= 1'b0;
      rem_q     <= '0;
    end else begin
      if (state_q == S_MEDE_TRIG)
        trig_ok_q <= trig_ok_q | (tw_conta & tw_fim);
      else
        trig_ok_q <= 1'b0;
      if (captura)
        rem_q <= d_bin;
      else if (state_q == S_ECO && tick_fim
               && rem_q != 10'd0)
        rem_q <= rem_q - 10'd1;
    end
  end

  assign echo      = echo_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_emulador_eco.sv
// Scoreboard bench for emulador_eco with
// shortened timing parameters.
module tb_emulador_eco;

  localparam int R    = 5;
  localparam int N    = 3;
  localparam int TMIN = 4;
  localparam int TA   = 10;
  localparam int TTO  = 60;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [3:0] digito0 = '0;
  logic [3:0] digito1 = '0;
  logic [3:0] digito2 = '0;
  logic       echo, pronto, erro;
  logic [2:0] db_estado;

  emulador_eco #(
    .R          (R),
    .N          (N),
    .T_TRIG_MIN (TMIN),
    .T_ATRASO   (TA),
    .T_TIMEOUT  (TTO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .trigger   (trigger),
    .digito0   (digito0),
    .digito1   (digito1),
    .digito2   (digito2),
    .echo      (echo),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int rise;
    int width;
    int pcyc;
    int erro;
  } resp_t;

  resp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int fall_cyc = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  nm, act, exp);
  endtask

  // monitor: measures echo, checks at each pronto
  initial begin
    int    cur_rise;
    int    cur_w;
    logic  prev_echo;
    logic  prev_pronto;
    resp_t e;
    cur_rise    = -1;
    cur_w       = 0;
    prev_echo   = 1'b0;
    prev_pronto = 1'b0;
    forever begin
      @(negedge clock);
      if (echo && !prev_echo) cur_rise = cyc;
      if (!echo && prev_echo) cur_w = cyc - cur_rise;
      if (pronto) begin
        chk("pronto_one_cycle", int'(prev_pronto), 0);
        chk("pronto_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("echo_rise", cur_rise, e.rise);
          chk("echo_width", cur_w, e.width);
          chk("pronto_cycle", cyc, e.pcyc);
          chk("erro_at_pronto", int'(erro), e.erro);
        end
        cur_rise = -1;
        cur_w    = 0;
      end
      if (reset) begin
        cur_rise = -1;
        cur_w    = 0;
      end
      prev_echo   = echo;
      prev_pronto = pronto;
    end
  end

  task automatic pulse(input int w,
                       input logic [3:0] d2,
                       input logic [3:0] d1,
                       input logic [3:0] d0);
    @(negedge clock);
    digito2 = d2;
    digito1 = d1;
    digito0 = d0;
    trigger = 1'b1;
    repeat (w) @(negedge clock);
    trigger  = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic expect_resp(input int d,
                             input int err);
    resp_t e;
    int w;
    w = d * R;
`ifdef ECO_TIMEOUT_EN
    if (d > 400) w = TTO;
`endif
    if (err != 0)
      e = '{-1, 0, fall_cyc + 3, 1};
    else if (d == 0)
      e = '{-1, 0, fall_cyc + 4 + TA, 0};
    else
      e = '{fall_cyc + 4 + TA, w,
            fall_cyc + 4 + TA + w, 0};
    sb.push_back(e);
  endtask

  task automatic wait_done(input string nm,
                           input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, sb.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_echo(input string nm,
                           input int budget);
    int n;
    n = 0;
    while (!echo && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, int'(echo), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_echo", int'(echo), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_state", int'(db_estado), 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("idle_state", int'(db_estado), 1);

    // minimum-width trigger, D = 100
    pulse(TMIN, 4'd1, 4'd0, 4'd0);
    expect_resp(100, 0);
    wait_done("t1_done", 100 * R + TA + 50);

    // D = 74
    pulse(6, 4'd0, 4'd7, 4'd4);
    expect_resp(74, 0);
    wait_done("t2_done", 74 * R + TA + 50);

    // too-short trigger: no response
    pulse(TMIN - 1, 4'd1, 4'd0, 4'd0);
    repeat (TA + 20) @(negedge clock);
    chk("short_state", int'(db_estado), 1);
    chk("short_echo", int'(echo), 0);

    // invalid tens digit
    pulse(5, 4'd0, 4'hA, 4'd0);
    expect_resp(0, 1);
    wait_done("t4_done", TA + 50);
    chk("erro_hold", int'(erro), 1);
    chk("erro_state", int'(db_estado), 1);

    // next valid trigger clears erro
    pulse(5, 4'd2, 4'd0, 4'd0);
    expect_resp(200, 0);
    wait_done("t4b_done", 200 * R + TA + 50);
    chk("erro_clear", int'(erro), 0);

    // reset in the middle of an echo
    pulse(5, 4'd1, 4'd0, 4'd0);
    wait_echo("t5_echo", TA + 20);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_echo", int'(echo), 0);
    chk("mid_rst_state", int'(db_estado), 0);
    chk("mid_rst_pronto", int'(pronto), 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    pulse(5, 4'd1, 4'd0, 4'd0);
    expect_resp(100, 0);
    wait_done("t5_done", 100 * R + TA + 50);

    // D = 500, re-trigger and new digits mid-echo
    pulse(5, 4'd5, 4'd0, 4'd0);
    expect_resp(500, 0);
    wait_echo("t6_echo", TA + 20);
    repeat (10) @(negedge clock);
    pulse(8, 4'd9, 4'd9, 4'd9);
    wait_done("t6_done", 500 * R + TA + 80);

    // D = 0: pronto only
    pulse(5, 4'd0, 4'd0, 4'd0);
    expect_resp(0, 0);
    wait_done("t7_done", TA + 50);

    // D = 999
    pulse(5, 4'd9, 4'd9, 4'd9);
    expect_resp(999, 0);
    wait_done("t8_done", 999 * R + TA + 50);

    // invalid hundreds digit, then D = 1
    pulse(5, 4'hF, 4'd0, 4'd1);
    expect_resp(0, 1);
    wait_done("t9_done", TA + 50);
    pulse(5, 4'd0, 4'd0, 4'd1);
    expect_resp(1, 0);
    wait_done("t10_done", R + TA + 50);
    chk("final_erro", int'(erro), 0);

    repeat (5) @(negedge clock);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
